// File: rtl/host_frame_demux_pkg.sv
// Shared link definitions for the two-board frame link.
// Used by the host multiplexer and the player-2 demultiplexer.
package host_frame_demux_pkg;

  localparam int WORD_W    = 16;
  localparam int PAYLOAD_W = 12;
  localparam int TAG_W     = 4;

  localparam logic [TAG_W-1:0] TAG_PL1X  = 4'd1;
  localparam logic [TAG_W-1:0] TAG_PL1Y  = 4'd2;
  localparam logic [TAG_W-1:0] TAG_BALLX = 4'd3;
  localparam logic [TAG_W-1:0] TAG_BALLY = 4'd4;
  localparam logic [TAG_W-1:0] TAG_FLAGS = 4'd5;

  localparam int SC1_HI  = 11;
  localparam int SC1_LO  = 8;
  localparam int SC2_HI  = 7;
  localparam int SC2_LO  = 4;
  localparam int FP_BIT  = 1;
  localparam int EG_BIT  = 0;

  typedef enum logic {
    WAIT_SYNC = 1'b0,
    COLLECT   = 1'b1
  } state_e;

  function automatic logic [TAG_W-1:0] tag_of(
    input logic [WORD_W-1:0] w
  );
    return w[WORD_W-1 -: TAG_W];
  endfunction

  function automatic logic [PAYLOAD_W-1:0] pay_of(
    input logic [WORD_W-1:0] w
  );
    return w[PAYLOAD_W-1:0];
  endfunction

  function automatic logic [7:0] sat_inc8(
    input logic [7:0] v
  );
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/host_frame_demux_if.sv
// Word stream from the UART 8-to-16 converter.
// No backpressure: a strobe marks one valid word.
interface host_frame_demux_if;
  import host_frame_demux_pkg::*;

  logic [WORD_W-1:0] data;
  logic              conv8to16valid;

  modport master (
    output data,
    output conv8to16valid
  );

  modport slave (
    input data,
    input conv8to16valid
  );

endinterface

// File: rtl/host_frame_demux_sat_timer.sv
// Up-counter that sticks at LIMIT; expired while parked there.
// Clear has priority over counting.
module sat_timer #(
  parameter int unsigned LIMIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam int unsigned W = $clog2(LIMIT + 1);

  logic [W-1:0] r_cnt;
  logic         w_exp;

  assign w_exp     = (r_cnt == W'(LIMIT));
  assign o_expired = w_exp;

  always_ff @(posedge clk) begin
    if (rst || i_clr)
      r_cnt <= '0;
    else if (i_en && !w_exp)
      r_cnt <= r_cnt + W'(1);
  end

endmodule

// File: rtl/host_frame_demux.sv
// Player-2 side frame parser: five tagged words in,
// atomically committed game state out.
module host_frame_demux
  import host_frame_demux_pkg::*;
#(
  parameter int unsigned WORD_GAP_MAX = 65000,
  parameter int unsigned LINK_TIMEOUT = 6500000
) (
  input  logic                  clk,
  input  logic                  rst,
  host_frame_demux_if.slave     rx,
  output logic [PAYLOAD_W-1:0]  pl1_posx,
  output logic [PAYLOAD_W-1:0]  pl1_posy,
  output logic [PAYLOAD_W-1:0]  ball_posx,
  output logic [PAYLOAD_W-1:0]  ball_posy,
  output logic [3:0]            pl1_score,
  output logic [3:0]            pl2_score,
  output logic                  flag_point,
  output logic                  end_game,
  output logic                  frame_valid,
  output logic                  link_up,
  output logic [7:0]            err_count
);

  state_e               r_state;
  logic [TAG_W-1:0]     r_exp_tag;
  logic [PAYLOAD_W-1:0] r_sh_px;
  logic [PAYLOAD_W-1:0] r_sh_py;
  logic [PAYLOAD_W-1:0] r_sh_bx;
  logic [PAYLOAD_W-1:0] r_sh_by;
  logic [PAYLOAD_W-1:0] r_px;
  logic [PAYLOAD_W-1:0] r_py;
  logic [PAYLOAD_W-1:0] r_bx;
  logic [PAYLOAD_W-1:0] r_by;
  logic [3:0]           r_s1;
  logic [3:0]           r_s2;
  logic                 r_fp;
  logic                 r_eg;
  logic                 r_fv;
  logic                 r_seen;
  logic [7:0]           r_err;

  logic                 w_stb;
  logic [TAG_W-1:0]     w_tag;
  logic [PAYLOAD_W-1:0] w_pay;
  logic                 w_in_col;
  logic                 w_commit;
  logic                 w_gap_clr;
  logic                 w_gap_exp;
  logic                 w_link_exp;

  assign w_stb    = rx.conv8to16valid;
  assign w_tag    = tag_of(rx.data);
  assign w_pay    = pay_of(rx.data);
  assign w_in_col = (r_state == COLLECT);
  assign w_commit = w_stb && w_in_col
                 && (r_exp_tag == TAG_FLAGS)
                 && (w_tag == TAG_FLAGS);
  // Gap only runs while a frame is open.
  assign w_gap_clr = w_stb || !w_in_col;

  sat_timer #(
    .LIMIT (WORD_GAP_MAX)
  ) u_gap (
    .clk       (clk),
    .rst       (rst),
    .i_clr     (w_gap_clr),
    .i_en      (1'b1),
    .o_expired (w_gap_exp)
  );

  sat_timer #(
    .LIMIT (LINK_TIMEOUT)
  ) u_link (
    .clk       (clk),
    .rst       (rst),
    .i_clr     (w_commit),
    .i_en      (1'b1),
    .o_expired (w_link_exp)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= WAIT_SYNC;
      r_exp_tag <= TAG_PL1X;
      r_sh_px   <= '0;
      r_sh_py   <= '0;
      r_sh_bx   <= '0;
      r_sh_by   <= '0;
      r_px      <= '0;
      r_py      <= '0;
      r_bx      <= '0;
      r_by      <= '0;
      r_s1      <= '0;
      r_s2      <= '0;
      r_fp      <= 1'b0;
      r_eg      <= 1'b0;
      r_fv      <= 1'b0;
      r_seen    <= 1'b0;
      r_err     <= '0;
    end else begin
      r_fv <= 1'b0;
      if (w_stb && !w_in_col) begin
        if (w_tag == TAG_PL1X) begin
          r_sh_px   <= w_pay;
          r_exp_tag <= TAG_PL1Y;
          r_state   <= COLLECT;
        end
      end else if (w_stb) begin
        if (w_commit) begin
          r_px      <= r_sh_px;
          r_py      <= r_sh_py;
          r_bx      <= r_sh_bx;
          r_by      <= r_sh_by;
          r_s1      <= w_pay[SC1_HI:SC1_LO];
          r_s2      <= w_pay[SC2_HI:SC2_LO];
          r_fp      <= w_pay[FP_BIT];
          r_eg      <= w_pay[EG_BIT];
          r_fv      <= 1'b1;
          r_seen    <= 1'b1;
          r_state   <= WAIT_SYNC;
          r_exp_tag <= TAG_PL1X;
        end else if (w_tag == r_exp_tag) begin
          unique case (1'b1)
            (r_exp_tag == TAG_PL1Y):  r_sh_py <= w_pay;
            (r_exp_tag == TAG_BALLX): r_sh_bx <= w_pay;
            (r_exp_tag == TAG_BALLY): r_sh_by <= w_pay;
            default: ;
          endcase
          r_exp_tag <= r_exp_tag + 4'd1;
        end else if (w_tag == TAG_PL1X) begin
          // Early tag 1 restarts the frame instead of dropping it.
          r_err     <= sat_inc8(r_err);
          r_sh_px   <= w_pay;
          r_exp_tag <= TAG_PL1Y;
        end else begin
          r_err     <= sat_inc8(r_err);
          r_state   <= WAIT_SYNC;
          r_exp_tag <= TAG_PL1X;
        end
      end else if (w_in_col && w_gap_exp) begin
        r_err     <= sat_inc8(r_err);
        r_state   <= WAIT_SYNC;
        r_exp_tag <= TAG_PL1X;
      end
    end
  end

  assign pl1_posx    = r_px;
  assign pl1_posy    = r_py;
  assign ball_posx   = r_bx;
  assign ball_posy   = r_by;
  assign pl1_score   = r_s1;
  assign pl2_score   = r_s2;
  assign flag_point  = r_fp;
  assign end_game    = r_eg;
  assign frame_valid = r_fv;
  assign link_up     = r_seen && !w_link_exp;
  assign err_count   = r_err;

endmodule

// File: tb/tb_host_frame_demux.sv
// Directed bench for host_frame_demux: word table plus
// hand-built gap, link, reset and saturation sequences.
module tb_host_frame_demux;

  localparam int GAP = 20;
  localparam int LNK = 200;

  typedef struct {
    logic [11:0] px;
    logic [11:0] py;
    logic [11:0] bx;
    logic [11:0] by;
    logic [3:0]  s1;
    logic [3:0]  s2;
    logic        fp;
    logic        eg;
  } vis_t;

  typedef struct {
    logic [15:0] w;
    logic        fv;
    logic        lu;
    logic [7:0]  err;
    vis_t        v;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [11:0] pl1_posx, pl1_posy, ball_posx, ball_posy;
  logic [3:0]  pl1_score, pl2_score;
  logic        flag_point, end_game, frame_valid, link_up;
  logic [7:0]  err_count;

  int n_cmp = 0;
  int n_bad = 0;

  host_frame_demux_if u_if ();

  host_frame_demux #(
    .WORD_GAP_MAX (GAP),
    .LINK_TIMEOUT (LNK)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rx          (u_if.slave),
    .pl1_posx    (pl1_posx),
    .pl1_posy    (pl1_posy),
    .ball_posx   (ball_posx),
    .ball_posy   (ball_posy),
    .pl1_score   (pl1_score),
    .pl2_score   (pl2_score),
    .flag_point  (flag_point),
    .end_game    (end_game),
    .frame_valid (frame_valid),
    .link_up     (link_up),
    .err_count   (err_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  function automatic vis_t mk(
    input logic [11:0] px, input logic [11:0] py,
    input logic [11:0] bx, input logic [11:0] by,
    input logic [3:0] s1, input logic [3:0] s2,
    input logic fp, input logic eg
  );
    vis_t r;
    r.px = px; r.py = py; r.bx = bx; r.by = by;
    r.s1 = s1; r.s2 = s2; r.fp = fp; r.eg = eg;
    return r;
  endfunction

  function automatic vec_t mv(
    input logic [15:0] w, input logic fv, input logic lu,
    input logic [7:0] err, input vis_t v
  );
    vec_t r;
    r.w = w; r.fv = fv; r.lu = lu; r.err = err; r.v = v;
    return r;
  endfunction

  task automatic chk(input string nm, input int idx,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d]: got %0h want %0h",
               nm, idx, act, exp);
    end
  endtask

  task automatic chk_vis(input string nm, input int idx,
                         input vis_t e);
    chk({nm, ".px"}, idx, 32'(pl1_posx),   32'(e.px));
    chk({nm, ".py"}, idx, 32'(pl1_posy),   32'(e.py));
    chk({nm, ".bx"}, idx, 32'(ball_posx),  32'(e.bx));
    chk({nm, ".by"}, idx, 32'(ball_posy),  32'(e.by));
    chk({nm, ".s1"}, idx, 32'(pl1_score),  32'(e.s1));
    chk({nm, ".s2"}, idx, 32'(pl2_score),  32'(e.s2));
    chk({nm, ".fp"}, idx, 32'(flag_point), 32'(e.fp));
    chk({nm, ".eg"}, idx, 32'(end_game),   32'(e.eg));
  endtask

  // Strobe one word; returns 1 ns into the following cycle.
  task automatic send(input logic [15:0] w);
    @(posedge clk); #1;
    u_if.data = w;
    u_if.conv8to16valid = 1'b1;
    @(posedge clk); #1;
    u_if.conv8to16valid = 1'b0;
  endtask

  vec_t        tv[$];
  logic [15:0] bb[5];
  logic [15:0] gw[5];
  vis_t        Z, F1, F2, F3, FB, FG, FL;

  initial begin
    u_if.data = '0;
    u_if.conv8to16valid = 1'b0;

    Z  = mk(12'h0,   12'h0,   12'h0,   12'h0,   4'h0, 4'h0, 0, 0);
    F1 = mk(12'h123, 12'h045, 12'h200, 12'h300, 4'hA, 4'h3, 0, 1);
    F2 = mk(12'h400, 12'h401, 12'h402, 12'h403, 4'hC, 4'h5, 1, 0);
    F3 = mk(12'h111, 12'h222, 12'h333, 12'h444, 4'h0, 4'h0, 0, 0);
    FB = mk(12'h777, 12'h888, 12'h999, 12'hAAA, 4'hF, 4'h0, 1, 1);
    FG = mk(12'h321, 12'h654, 12'h987, 12'hCBA, 4'h6, 4'h9, 1, 0);
    FL = mk(12'h010, 12'h020, 12'h030, 12'h040, 4'h1, 4'h2, 0, 0);

    tv.push_back(mv(16'h1123, 0, 0, 8'd0, Z));
    tv.push_back(mv(16'h2045, 0, 0, 8'd0, Z));
    tv.push_back(mv(16'h3200, 0, 0, 8'd0, Z));
    tv.push_back(mv(16'h4300, 0, 0, 8'd0, Z));
    tv.push_back(mv(16'h5A31, 1, 1, 8'd0, F1));
    tv.push_back(mv(16'h1001, 0, 1, 8'd0, F1));
    tv.push_back(mv(16'h3002, 0, 1, 8'd1, F1));
    tv.push_back(mv(16'h1400, 0, 1, 8'd1, F1));
    tv.push_back(mv(16'h2401, 0, 1, 8'd1, F1));
    tv.push_back(mv(16'h3402, 0, 1, 8'd1, F1));
    tv.push_back(mv(16'h4403, 0, 1, 8'd1, F1));
    tv.push_back(mv(16'h5C52, 1, 1, 8'd1, F2));
    tv.push_back(mv(16'h1010, 0, 1, 8'd1, F2));
    tv.push_back(mv(16'h2020, 0, 1, 8'd1, F2));
    tv.push_back(mv(16'h1111, 0, 1, 8'd2, F2));
    tv.push_back(mv(16'h2222, 0, 1, 8'd2, F2));
    tv.push_back(mv(16'h3333, 0, 1, 8'd2, F2));
    tv.push_back(mv(16'h4444, 0, 1, 8'd2, F2));
    tv.push_back(mv(16'h5000, 1, 1, 8'd2, F3));
    tv.push_back(mv(16'h1ABC, 0, 1, 8'd2, F3));
    tv.push_back(mv(16'h0FFF, 0, 1, 8'd3, F3));
    tv.push_back(mv(16'h2999, 0, 1, 8'd3, F3));
    tv.push_back(mv(16'hF000, 0, 1, 8'd3, F3));
    tv.push_back(mv(16'h1001, 0, 1, 8'd3, F3));
    tv.push_back(mv(16'h2002, 0, 1, 8'd3, F3));
    tv.push_back(mv(16'h6000, 0, 1, 8'd4, F3));
    tv.push_back(mv(16'h5123, 0, 1, 8'd4, F3));

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst.fv",  0, 32'(frame_valid), 32'd0);
    chk("rst.lu",  0, 32'(link_up),     32'd0);
    chk("rst.err", 0, 32'(err_count),   32'd0);
    chk_vis("rst", 0, Z);

    for (int i = 0; i < tv.size(); i++) begin
      send(tv[i].w);
      chk("tv.fv",  i, 32'(frame_valid), 32'(tv[i].fv));
      chk("tv.lu",  i, 32'(link_up),     32'(tv[i].lu));
      chk("tv.err", i, 32'(err_count),   32'(tv[i].err));
      chk_vis("tv", i, tv[i].v);
      @(posedge clk);
    end

    // back-to-back strobes, no idle cycles
    bb[0] = 16'h1777; bb[1] = 16'h2888; bb[2] = 16'h3999;
    bb[3] = 16'h4AAA; bb[4] = 16'h5F03;
    @(posedge clk); #1;
    u_if.conv8to16valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      u_if.data = bb[k];
      @(posedge clk); #1;
    end
    u_if.conv8to16valid = 1'b0;
    chk("bb.fv",  0, 32'(frame_valid), 32'd1);
    chk("bb.err", 0, 32'(err_count),   32'd4);
    chk_vis("bb", 0, FB);
    @(posedge clk); #1;
    chk("bb.fv",  1, 32'(frame_valid), 32'd0);

    // exactly GAP idle cycles between words: strobe wins
    gw[0] = 16'h1321; gw[1] = 16'h2654; gw[2] = 16'h3987;
    gw[3] = 16'h4CBA; gw[4] = 16'h5692;
    for (int k = 0; k < 5; k++) begin
      send(gw[k]);
      if (k < 4) repeat (GAP - 1) @(posedge clk);
    end
    chk("gapok.fv",  0, 32'(frame_valid), 32'd1);
    chk("gapok.err", 0, 32'(err_count),   32'd4);
    chk_vis("gapok", 0, FG);

    // GAP+1 idle cycles: timeout, rest of frame discarded
    send(16'h1005);
    repeat (GAP) @(posedge clk);
    send(16'h2AAA);
    chk("gapto.err", 0, 32'(err_count), 32'd5);
    send(16'h3BBB);
    send(16'h4CCC);
    send(16'h5DDD);
    chk("gapto.fv",  0, 32'(frame_valid), 32'd0);
    chk("gapto.err", 1, 32'(err_count),   32'd5);
    chk_vis("gapto", 0, FG);

    // link drops exactly LNK cycles after the commit cycle
    send(16'h1010);
    send(16'h2020);
    send(16'h3030);
    send(16'h4040);
    send(16'h5120);
    chk("lnk.fv", 0, 32'(frame_valid), 32'd1);
    chk("lnk.lu", 0, 32'(link_up),     32'd1);
    chk_vis("lnk", 0, FL);
    repeat (LNK - 1) @(posedge clk);
    #1;
    chk("lnk.lu", 1, 32'(link_up), 32'd1);
    @(posedge clk); #1;
    chk("lnk.lu", 2, 32'(link_up), 32'd0);

    // reset mid-frame after tag 3
    send(16'h1AAA);
    send(16'h2BBB);
    send(16'h3CCC);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    chk("mrst.err", 0, 32'(err_count), 32'd0);
    chk("mrst.lu",  0, 32'(link_up),   32'd0);
    chk_vis("mrst", 0, Z);
    send(16'h4DDD);
    chk("mrst.err", 1, 32'(err_count),   32'd0);
    chk("mrst.fv",  0, 32'(frame_valid), 32'd0);
    send(16'h5EEE);
    chk("mrst.fv",  1, 32'(frame_valid), 32'd0);
    chk("mrst.err", 2, 32'(err_count),   32'd0);
    chk_vis("mrst", 1, Z);

    // error counter saturation
    for (int k = 0; k < 260; k++) begin
      send(16'h1001);
      send(16'h0000);
    end
    chk("sat.err", 0, 32'(err_count), 32'd255);
    chk_vis("sat", 0, Z);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
